ctrl_pipe_flush: RTL
====================

// Module: ctrl_pipe_flush
// PURPOSE
//  Parametrised control-signal pipeline carrying decode control bits (wb, mem, ex fields) through DEPTH stages.
//  Per-stage flush replaces a stage's contents with a bubble; global stall freezes the pipe.
//  Sits between the decode and writeback control paths and replaces the single-bit bubble muxes.
//  Guarantees that squashed instructions never assert write-enables downstream.
// PARAMETERS
//  WIDTH       8      control bits carried per stage (>=1)
//  DEPTH       2      number of register stages (>=1); stage 0 is nearest the input
//  BUBBLE_VAL  0      WIDTH-bit value written into a stage when it holds a bubble
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           asynchronous, active-high reset
//  in_ctrl      in   WIDTH       control word from the issuing stage
//  in_valid     in   1           in_ctrl carries a live instruction
//  stall        in   1           hold all stages (hazard unit)
//  flush        in   DEPTH       flush[k]=1: stage k loads a bubble at next edge
//  out_ctrl     out  WIDTH       control word of stage DEPTH-1
//  out_valid    out  1           stage DEPTH-1 holds a live instruction
//  stage_valid  out  DEPTH       valid bit of every stage, bit k = stage k
// BEHAVIOUR
//  - Reset (async, rst=1): every stage ctrl=BUBBLE_VAL, valid=0; out_ctrl=BUBBLE_VAL, out_valid=0, stage_valid=0.
//    Reset mid-operation discards all contents immediately, without waiting for a clock edge.
//  - Bubble = {valid=0, ctrl=BUBBLE_VAL}. Invariant: valid=0 implies ctrl==BUBBLE_VAL, in every stage, on every cycle.
//  - Input capture: in_valid=0 is captured as a bubble, whatever in_ctrl holds.
//  - Per edge, stage k next-state, in priority order:
//      1. flush[k]=1           -> bubble (wins over stall)
//      2. stall=1              -> hold current contents
//      3. otherwise            -> k=0 takes the input; k>0 takes stage k-1
//  - Stall with no flush: the input is ignored; the issuer must hold in_ctrl/in_valid.
//  - Stall with flush[k]: stage k becomes a bubble; other stages hold.
//  - Flushing stage k does not affect stage k+1 in the same edge: stage k+1 still takes k's old contents unless flush[k+1].
//  - Latency: a word accepted at edge N appears on out_ctrl after edge N+DEPTH-1, with no stalls or flushes.
//  - Outputs are registered; no combinational path from inputs to out_ctrl or out_valid.
//  - DEPTH=1: a single register; flush[0] and stall behave as above.
// CONFIGURATION
//  Macro CTRL_PIPE_STATS_EN.
//  Defined: adds output ports squash_cnt [15:0] and stall_cnt [15:0], reset to 0.
//    - squash_cnt += popcount of stages with flush[k]=1 and valid=1 at that edge.
//    - stall_cnt += 1 per edge with stall=1.
//    - Both counters saturate at 16'hFFFF.
//  Not defined: neither port nor counter logic exists; all other behaviour is identical.
// TESTING
//  1. Reset: rst=1 mid-stream -> out_valid=0, stage_valid=0, out_ctrl=BUBBLE_VAL, without a clock edge.
//  2. Flow, DEPTH=2, WIDTH=8: in_ctrl=8'hA5,valid=1 at edge 0 -> out_ctrl=8'hA5, out_valid=1 after edge 1.
//  3. Flush, DEPTH=2: stage0=8'h11, stage1=8'h22; flush=2'b01 -> after the edge, stage1=8'h11, stage0=bubble.
//  4. Stall plus flush: stall=1 for 3 edges, flush=2'b10 on the 2nd -> stage0 holds; stage1 becomes a bubble and stays one.
//  5. Invalid input: in_valid=0 with in_ctrl=8'hFF -> the stage captures 8'h00 (BUBBLE_VAL=0), valid=0.
//  6. With CTRL_PIPE_STATS_EN: flush=2'b11 with both stages valid -> squash_cnt += 2; 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/ctrl_pipe_flush_if.sv
// Bundle of the control-pipeline signals between the issuing stage and ctrl_pipe_flush.
// The squash_cnt/stall_cnt observation ports exist only when CTRL_PIPE_STATS_EN is defined.
interface ctrl_pipe_flush_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);
   logic [WIDTH-1:0] in_ctrl;
   logic             in_valid;
   logic             stall;
   logic [DEPTH-1:0] flush;
   logic [WIDTH-1:0] out_ctrl;
   logic             out_valid;
   logic [DEPTH-1:0] stage_valid;
`ifdef CTRL_PIPE_STATS_EN
   logic [15:0]      squash_cnt;
   logic [15:0]      stall_cnt;

   modport master (
      output in_ctrl, in_valid, stall, flush,
      input  out_ctrl, out_valid, stage_valid, squash_cnt, stall_cnt
   );
   modport slave (
      input  in_ctrl, in_valid, stall, flush,
      output out_ctrl, out_valid, stage_valid, squash_cnt, stall_cnt
   );
`else
   modport master (
      output in_ctrl, in_valid, stall, flush,
      input  out_ctrl, out_valid, stage_valid
   );
   modport slave (
      input  in_ctrl, in_valid, stall, flush,
      output out_ctrl, out_valid, stage_valid
   );
`endif
endinterface

// File: rtl/ctrl_pipe_flush.sv
// DEPTH-stage decode-control pipeline with per-stage flush (bubble insert) and global stall.
// Define CTRL_PIPE_STATS_EN to add saturating squash/stall event counters.
module ctrl_pipe_flush #(
   parameter int               WIDTH      = 8,
   parameter int               DEPTH      = 2,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
   input logic              clk,
   input logic              rst,
   ctrl_pipe_flush_if.slave bus
);

   logic [WIDTH-1:0] ctrl_p [DEPTH];
   logic [DEPTH-1:0] vld_p;
   logic [WIDTH-1:0] src_ctrl [DEPTH];
   logic [DEPTH-1:0] src_vld;

   // An invalid input is normalised to a bubble so valid=0 always pairs with BUBBLE_VAL
   always_comb begin
      src_ctrl[0] = bus.in_valid ? bus.in_ctrl : BUBBLE_VAL;
      src_vld[0]  = bus.in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         src_ctrl[k] = ctrl_p[k-1];
         src_vld[k]  = vld_p[k-1];
      end
   end

   // Stage registers: flush beats stall, stall beats shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) ctrl_p[k] <= BUBBLE_VAL;
         vld_p <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (bus.flush[k]) begin
               ctrl_p[k] <= BUBBLE_VAL;
               vld_p[k]  <= 1'b0;
            end else if (!bus.stall) begin
               ctrl_p[k] <= src_ctrl[k];
               vld_p[k]  <= src_vld[k];
            end
         end
      end
   end

   assign bus.out_ctrl    = ctrl_p[DEPTH-1];
   assign bus.out_valid   = vld_p[DEPTH-1];
   assign bus.stage_valid = vld_p;

`ifdef CTRL_PIPE_STATS_EN
   logic [15:0] squash_q;
   logic [15:0] stall_q;
   logic [15:0] squash_inc;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // Only live instructions count as squashed; flushing a bubble is free
   always_comb begin
      squash_inc = '0;
      for (int k = 0; k < DEPTH; k++)
         squash_inc = squash_inc + 16'(bus.flush[k] & vld_p[k]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         squash_q <= '0;
         stall_q  <= '0;
      end else begin
         squash_q <= sat_add16(squash_q, squash_inc);
         stall_q  <= sat_add16(stall_q, 16'(bus.stall));
      end
   end

   assign bus.squash_cnt = squash_q;
   assign bus.stall_cnt  = stall_q;
`endif

endmodule
